// File: rtl/gray_pkg.sv
// Shared state encoding, step-class codes and counter width for the Gray-code
// step monitor and its decoder.
package gray_pkg;

    localparam int ERR_CNT_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACQ   = 2'd1;
    localparam state_t ST_LOCK  = 2'd2;
    localparam state_t ST_FAULT = 2'd3;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_NONE = 2'b00;
    localparam dir_t DIR_UP   = 2'b01;
    localparam dir_t DIR_DN   = 2'b10;
    localparam dir_t DIR_ERR  = 2'b11;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational reflected-Gray to binary decoder of parameterisable width.
module gray_to_bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of every Gray bit at or above its position.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_step_monitor.sv
// Decodes a stream of Gray samples, classifies each step against the previous
// sample and tracks lock / fault status behind a ready/valid output register.
module gray_step_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [WIDTH-1:0]     gray_i,
    input  logic                 gray_valid_i,
    output logic                 gray_ready_o,
    input  logic                 clear_i,
    output logic [WIDTH-1:0]     bin_o,
    output logic [1:0]           dir_o,
    output logic                 step_err_o,
    output logic                 bin_valid_o,
    input  logic                 bin_ready_i,
    output logic                 locked_o,
    output logic                 fault_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int RUN_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic [WIDTH-1:0] prev_gray_q;
    logic [WIDTH-1:0] prev_bin_q;
    logic [WIDTH-1:0] bin_dec;
    logic [WIDTH-1:0] diff;
    logic             accept;
    logic             first;
    logic             one_bit;
    logic             multi_bit;
    logic             is_up;
    logic             lock_hit;
    logic             count_err;
    dir_t             dir_d;
    logic             err_d;

    assign gray_ready_o = !bin_valid_o || bin_ready_i;
    assign accept       = gray_valid_i && gray_ready_o;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_gray_to_bin (
        .gray (gray_i),
        .bin  (bin_dec)
    );

    // A single changed Gray bit is a legal step; clearing the lowest set bit
    // of the difference leaves zero exactly in that case.
    assign diff      = gray_i ^ prev_gray_q;
    assign one_bit   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    assign multi_bit = (diff != '0) && !one_bit;
    assign is_up     = (bin_dec == prev_bin_q + WIDTH'(1));
    assign first     = clear_i || (state_q == ST_IDLE);
    assign lock_hit  = (int'(run_q) + 1) >= (LOCK_CNT - 1);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path infers a latch.
        state_d   = state_q;
        run_d     = run_q;
        dir_d     = DIR_NONE;
        err_d     = 1'b0;
        count_err = 1'b0;
        if (accept) begin
            if (first) begin
                state_d = ST_ACQ;
                run_d   = '0;
            end else begin
                if (multi_bit) begin
                    dir_d     = DIR_ERR;
                    err_d     = 1'b1;
                    count_err = 1'b1;
                end else if (one_bit) begin
                    dir_d = is_up ? DIR_UP : DIR_DN;
                end
                case (state_q)
                    ST_ACQ: begin
                        if (multi_bit) begin
                            run_d = '0;
                        end else if (one_bit) begin
                            if (lock_hit) begin
                                state_d = ST_LOCK;
                                run_d   = RUN_W'(LOCK_CNT - 1);
                            end else begin
                                run_d = run_q + RUN_W'(1);
                            end
                        end
                    end
                    ST_LOCK: begin
                        if (multi_bit) begin
                            state_d = ST_FAULT;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (clear_i) begin
            state_d = ST_IDLE;
            run_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            run_q       <= '0;
            prev_gray_q <= '0;
            prev_bin_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            if (accept) begin
                prev_gray_q <= gray_i;
                prev_bin_q  <= bin_dec;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= '0;
        end else if (clear_i) begin
            err_cnt_o <= '0;
        end else if (count_err && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
    end

    // NOTE: the data registers are reset too, because their reset value is visible on the ports.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_valid_o <= 1'b0;
            bin_o       <= '0;
            dir_o       <= DIR_NONE;
            step_err_o  <= 1'b0;
        end else if (accept) begin
            bin_valid_o <= 1'b1;
            bin_o       <= bin_dec;
            dir_o       <= dir_d;
            step_err_o  <= err_d;
        end else if (bin_ready_i) begin
            bin_valid_o <= 1'b0;
        end
    end

    assign locked_o = (state_q == ST_LOCK);
    assign fault_o  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_gray_step_monitor.sv
// Self-checking bench for gray_step_monitor: a reference model pushes expected
// outputs on every accepted sample and a monitor pops them on each handshake.
module tb_gray_step_monitor;

    localparam int W    = 8;
    localparam int LOCK = 4;

    typedef struct packed {
        logic [W-1:0] bin;
        logic [1:0]   dir;
        logic         err;
        logic         locked;
        logic         fault;
        logic [7:0]   cnt;
    } exp_t;

    typedef enum int {M_IDLE, M_ACQ, M_LOCK, M_FAULT} mstate_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] gray;
    logic         gray_valid;
    logic         gray_ready;
    logic         clear;
    logic [W-1:0] bin;
    logic [1:0]   dir;
    logic         step_err;
    logic         bin_valid;
    logic         bin_ready;
    logic         locked;
    logic         fault;
    logic [7:0]   err_cnt;

    int      checks = 0;
    int      errors = 0;
    int      last_wait = 0;
    exp_t    sb[$];
    mstate_t m_state;
    int      m_run;
    int      m_cnt;
    logic [W-1:0] m_prev;

    gray_step_monitor #(
        .WIDTH    (W),
        .LOCK_CNT (LOCK)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .gray_i       (gray),
        .gray_valid_i (gray_valid),
        .gray_ready_o (gray_ready),
        .clear_i      (clear),
        .bin_o        (bin),
        .dir_o        (dir),
        .step_err_o   (step_err),
        .bin_valid_o  (bin_valid),
        .bin_ready_i  (bin_ready),
        .locked_o     (locked),
        .fault_o      (fault),
        .err_cnt_o    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_run   = 0;
        m_cnt   = 0;
        m_prev  = '0;
    endtask

    task automatic model_clear();
        m_state = M_IDLE;
        m_run   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_accept(input logic [W-1:0] g, input logic clr);
        exp_t         e;
        logic [W-1:0] b;
        logic [W-1:0] pb;
        logic [W-1:0] delta;
        int           nd;
        b     = from_gray(g);
        pb    = from_gray(m_prev);
        delta = b - pb;
        nd    = $countones(g ^ m_prev);
        e.bin = b;
        e.dir = 2'b00;
        e.err = 1'b0;
        if (clr) m_cnt = 0;
        if (clr || m_state == M_IDLE) begin
            m_state = M_ACQ;
            m_run   = 0;
        end else if (nd == 1) begin
            e.dir = (delta == 1) ? 2'b01 : 2'b10;
            if (m_state == M_ACQ) begin
                m_run++;
                if (m_run >= LOCK - 1) m_state = M_LOCK;
            end
        end else if (nd > 1) begin
            e.dir = 2'b11;
            e.err = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (m_state == M_ACQ) m_run = 0;
            else if (m_state == M_LOCK) m_state = M_FAULT;
        end
        m_prev   = g;
        e.locked = (m_state == M_LOCK);
        e.fault  = (m_state == M_FAULT);
        e.cnt    = 8'(m_cnt);
        sb.push_back(e);
    endtask

    // Offers one sample from posedge+1 and returns at posedge+1 after it is taken.
    task automatic send(input logic [W-1:0] g, input logic clr);
        int waited;
        waited     = 0;
        gray       = g;
        gray_valid = 1'b1;
        clear      = clr;
        @(negedge clk);
        while (!gray_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (gray_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout gray=%h waited=%0d cycles, needed ready within 50", g, waited);
            gray_valid = 1'b0;
            clear      = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(g, clr);
        last_wait = waited;
        #1;
        gray_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic drain();
        gray_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bin_valid === 1'b1 && bin_ready === 1'b1) begin
                a = {bin, dir, step_err, locked, fault, err_cnt};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected got bin=%h dir=%b with no sample pending", bin, dir);
                end else begin
                    e = sb.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL out_check got bin=%h dir=%b err=%b lock=%b fault=%b cnt=%0d want bin=%h dir=%b err=%b lock=%b fault=%b cnt=%0d",
                                 a.bin, a.dir, a.err, a.locked, a.fault, a.cnt,
                                 e.bin, e.dir, e.err, e.locked, e.fault, e.cnt);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n      = 1'b0;
        gray       = '0;
        gray_valid = 1'b0;
        clear      = 1'b0;
        bin_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bin_valid, bin, dir, step_err, locked, fault, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b bin=%h dir=%b err=%b lock=%b fault=%b cnt=%0d want all zero",
                     bin_valid, bin, dir, step_err, locked, fault, err_cnt);
        end
        rst_n = 1'b1;
        checks++;
        if (gray_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", gray_ready);
        end
    endtask

    task automatic test_ascending();
        for (int i = 0; i < 256; i++) send(to_gray(W'(i)), 1'b0);
        drain();
        checks++;
        if (err_cnt !== 8'd0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL ascend_state got cnt=%0d lock=%b want cnt=0 lock=1", err_cnt, locked);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL ascend_pending got %0d want 0", sb.size());
        end
    endtask

    task automatic test_wrap();
        send(to_gray(8'h00), 1'b0);
        send(to_gray(8'hFF), 1'b0);
        send(to_gray(8'h00), 1'b0);
        drain();
        checks++;
        if (sb.size() != 0 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pending got %0d err=%b want 0 err=0", sb.size(), step_err);
        end
    endtask

    task automatic test_fault();
        send(8'h03, 1'b0);
        send(8'h07, 1'b0);
        drain();
        checks++;
        if (fault !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL fault_state got fault=%b lock=%b cnt=%0d want 1 0 1", fault, locked, err_cnt);
        end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_clear();
        checks++;
        if (fault !== 1'b0 || locked !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clear_state got fault=%b lock=%b cnt=%0d want 0 0 0", fault, locked, err_cnt);
        end
        send(to_gray(8'h40), 1'b0);
        send(to_gray(8'h41), 1'b0);
        send(8'hFF, 1'b0);
        drain();
        checks++;
        if (err_cnt !== 8'd1 || fault !== 1'b0 || locked !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL acq_error got cnt=%0d fault=%b lock=%b pending=%0d want 1 0 0 0",
                     err_cnt, fault, locked, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 0; i < 8; i++) send(to_gray(W'(8'h50 + i)), i == 0);
            end
            begin
                logic [W+2:0] held;
                held = '0;
                repeat (3) @(posedge clk);
                #1;
                bin_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if (gray_ready !== 1'b0 || bin_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_ready got ready=%b valid=%b want 0 1", gray_ready, bin_valid);
                    end
                    if (k == 0) begin
                        held = {bin, dir, step_err};
                    end else begin
                        checks++;
                        if ({bin, dir, step_err} !== held) begin
                            errors++;
                            $display("FAIL stall_hold got %h want %h", {bin, dir, step_err}, held);
                        end
                    end
                end
                @(posedge clk);
                #1;
                bin_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stall_pending got %0d want 0", sb.size());
        end
    endtask

    task automatic test_saturate();
        send(8'h00, 1'b1);
        for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 8'h03 : 8'h00, 1'b0);
        drain();
        checks++;
        if (err_cnt !== 8'd255 || sb.size() != 0) begin
            errors++;
            $display("FAIL saturate got cnt=%0d pending=%0d want 255 0", err_cnt, sb.size());
        end
    endtask

    task automatic test_async_reset();
        send(to_gray(8'h20), 1'b1);
        send(to_gray(8'h21), 1'b0);
        send(to_gray(8'h22), 1'b0);
        send(to_gray(8'h23), 1'b0);
        send(8'h00, 1'b0);
        drain();
        checks++;
        if (fault !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset got fault=%b cnt=%0d want 1 1", fault, err_cnt);
        end
        bin_ready = 1'b0;
        send(to_gray(8'h24), 1'b0);
        #1;
        checks++;
        if (bin_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got %b want 1", bin_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bin_valid, bin, dir, step_err, locked, fault, err_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset got valid=%b bin=%h dir=%b err=%b lock=%b fault=%b cnt=%0d want all zero",
                     bin_valid, bin, dir, step_err, locked, fault, err_cnt);
        end
        sb.delete();
        model_reset();
        bin_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(to_gray(8'h66), 1'b0);
        checks++;
        if (last_wait != 0) begin
            errors++;
            $display("FAIL first_edge got wait=%0d want 0", last_wait);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset_pending got %0d want 0", sb.size());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ascending();
        test_wrap();
        test_fault();
        test_back_to_back();
        test_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
